cam_lookup_arb: RTL and testbench



---
 rtl/cam_lookup_arb_if.sv | 28 ++
 rtl/cam_lookup_arb.sv | 160 ++++++++++++++++
 tb/tb_cam_lookup_arb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/cam_lookup_arb_if.sv
// Request/response bus between the requesters and cam_lookup_arb.
//   req_valid/req_data/req_ready : per-requester lookup request, one-hot accept
//   rsp_valid/rsp_hit/rsp_addr   : one-hot held response with captured engine result
//   rsp_ready                    : response accept from the owning requester
// slave  = arbiter side, master = requester side.
interface cam_lookup_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_hit;
  logic [ADDR_W-1:0]         rsp_addr;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_addr
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_addr
  );
endinterface

// File: rtl/cam_lookup_arb.sv
// Round-robin arbiter sharing one registered CAM lookup engine among NUM_REQ
// requesters. One lookup in flight at a time: IDLE -> ISSUE -> CAPTURE -> RESP.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response handshake bus (req_ready is combinational)
//   cam_enable      : engine enable, high only in ISSUE
//   cam_data_out    : latched lookup data of the granted requester
//   cam_hit_in/addr : engine registered result, captured at the end of CAPTURE
//   busy            : high whenever the FSM is not in IDLE
//   lookup_cnt      : completed-lookup counter, 16-bit wrapping
module cam_lookup_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cam_lookup_arb_if.slave     bus,
  output logic                cam_enable,
  output logic [DATA_W-1:0]   cam_data_out,
  input  logic                cam_hit_in,
  input  logic [ADDR_W-1:0]   cam_addr_in,
  output logic                busy,
  output logic [15:0]         lookup_cnt
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               cam_enable_q, cam_enable_d;
  logic [DATA_W-1:0]  cam_data_q, cam_data_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ready_c;

  logic               any_req;
  logic [IDX_W-1:0]   pick_idx;
  logic [SUM_W-1:0]   sum;
  logic [DATA_W-1:0]  pick_data;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_req  = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      if (!any_req && bus.req_valid[sum[IDX_W-1:0]]) begin
        any_req  = 1'b1;
        pick_idx = sum[IDX_W-1:0];
      end
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) pick_data = bus.req_data[k*DATA_W +: DATA_W];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    cam_enable_d = 1'b0;
    cam_data_d   = cam_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_addr_d   = rsp_addr_q;
    cnt_d        = cnt_q;
    req_ready_c  = '0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          // req_ready is one-hot on a requester whose valid is high, so
          // any_req alone marks the handshake.
          req_ready_c  = ONE_HOT0 << pick_idx;
          cam_data_d   = pick_data;
          gnt_idx_d    = pick_idx;
          rr_ptr_d     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          cam_enable_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // Engine result for the ISSUE cycle is valid at this edge.
        rsp_hit_d   = cam_hit_in;
        rsp_addr_d  = cam_addr_in;
        cnt_d       = cnt_q + CNT_W'(1);
        rsp_valid_d = ONE_HOT0 << gnt_idx_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      cam_enable_q <= 1'b0;
      cam_data_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_addr_q   <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      cam_enable_q <= cam_enable_d;
      cam_data_q   <= cam_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_addr_q   <= rsp_addr_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  // req_ready is forced low while reset is asserted.
  assign bus.req_ready = rst_n ? req_ready_c : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign cam_enable    = cam_enable_q;
  assign cam_data_out  = cam_data_q;
  assign busy          = busy_q;
  assign lookup_cnt    = cnt_q;

endmodule

// File: tb/tb_cam_lookup_arb.sv
// Directed self-checking bench for cam_lookup_arb with a registered
// lowest-set-bit priority encoder standing in for the CAM engine.
module tb_cam_lookup_arb;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cam_enable;
  logic [DATA_W-1:0] cam_data_out;
  logic              cam_hit_in;
  logic [ADDR_W-1:0] cam_addr_in;
  logic              busy;
  logic [15:0]       lookup_cnt;

  int total = 0;
  int bad   = 0;

  cam_lookup_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cam_lookup_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cam_enable   (cam_enable),
    .cam_data_out (cam_data_out),
    .cam_hit_in   (cam_hit_in),
    .cam_addr_in  (cam_addr_in),
    .busy         (busy),
    .lookup_cnt   (lookup_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] lsb_idx(input logic [DATA_W-1:0] d);
    lsb_idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) if (d[i]) lsb_idx = ADDR_W'(i);
  endfunction

  // Engine model: registered priority encoder, zero output when not enabled.
  always_ff @(posedge clk) begin
    cam_hit_in  <= cam_enable && (|cam_data_out);
    cam_addr_in <= cam_enable ? lsb_idx(cam_data_out) : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"},  32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_hit"},    32'(bus.rsp_hit),   32'h0);
    chk({tag, "_rsp_addr"},   32'(bus.rsp_addr),  32'h0);
    chk({tag, "_cam_enable"}, 32'(cam_enable),    32'h0);
    chk({tag, "_cam_data"},   32'(cam_data_out),  32'h0);
    chk({tag, "_busy"},       32'(busy),          32'h0);
    chk({tag, "_cnt"},        32'(lookup_cnt),    32'h0);
    chk({tag, "_req_ready"},  32'(bus.req_ready), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] hold_data;
    logic [3:0]        g_oh;
    int                g;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with requests asserted to show req_ready held low.
    bus.req_valid = 4'b1111;
    #1;
    chk_all_zero("reset");

    // Single request from requester 2: data 0x0100 -> hit, addr 8.
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data[2*DATA_W +: DATA_W] = 16'h0100;
    #1;
    chk("t1_req_ready", 32'(bus.req_ready), 32'h4);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t1_issue_en",    32'(cam_enable),    32'h1);
    chk("t1_issue_data",  32'(cam_data_out),  32'h0100);
    chk("t1_issue_busy",  32'(busy),          32'h1);
    chk("t1_issue_ready", 32'(bus.req_ready), 32'h0);
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_cap_en",    32'(cam_enable),    32'h0);
    chk("t1_cap_rsp",   32'(bus.rsp_valid), 32'h0);
    chk("t1_cap_data",  32'(cam_data_out),  32'h0100);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    chk("t1_rsp_hit",   32'(bus.rsp_hit),   32'h1);
    chk("t1_rsp_addr",  32'(bus.rsp_addr),  32'h8);
    chk("t1_cnt",       32'(lookup_cnt),    32'h1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t1_done_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t1_done_busy",  32'(busy),          32'h0);

    // Miss from requester 0 (rr_ptr=3 wraps to 0).
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: DATA_W] = 16'h0000;
    #1;
    chk("t2_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t2_rsp_hit",   32'(bus.rsp_hit),   32'h0);
    chk("t2_rsp_addr",  32'(bus.rsp_addr),  32'h0);
    chk("t2_cnt",       32'(lookup_cnt),    32'h2);
    @(negedge clk);

    // Backpressure: requester 0 lookup held in RESP with requester 1 pending.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    bus.req_data[0 +: DATA_W] = 16'h8000;
    #1;
    chk("t3_req_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0010;
    bus.req_data[1*DATA_W +: DATA_W] = 16'h0006;
    @(negedge clk);
    @(negedge clk);
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_rsp_hit",   32'(bus.rsp_hit),   32'h1);
    chk("t3_rsp_addr",  32'(bus.rsp_addr),  32'hF);
    chk("t3_cnt",       32'(lookup_cnt),    32'h3);
    repeat (10) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t3_hold_hit",   32'(bus.rsp_hit),   32'h1);
      chk("t3_hold_addr",  32'(bus.rsp_addr),  32'hF);
      chk("t3_hold_ready", 32'(bus.req_ready), 32'h0);
      chk("t3_hold_en",    32'(cam_enable),    32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 32'(bus.rsp_valid), 32'h0);
    #1;
    chk("t3_next_ready", 32'(bus.req_ready), 32'h2);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("t3_next_en",   32'(cam_enable),   32'h1);
    chk("t3_next_data", 32'(cam_data_out), 32'h0006);
    bus.req_valid = '0;
    @(negedge clk);
    chk("t4_cap_busy", 32'(busy), 32'h1);

    // Reset during CAPTURE: everything clears immediately.
    rst_n = 1'b0;
    #1;
    chk_all_zero("t4_midreset");
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      hold_data = 16'h0001 << (4 * i + 1);
      bus.req_data[i*DATA_W +: DATA_W] = hold_data;
    end
    #1;
    chk("t4_rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_no_rsp", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;

    // Round-robin with all requests high and rsp_ready tied 1: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      g_oh = 4'b0001 << g;
      if (k != 0) #1;
      chk("t5_req_ready", 32'(bus.req_ready), 32'(g_oh));
      @(negedge clk);
      hold_data = 16'h0001 << (4 * g + 1);
      chk("t5_issue_en",   32'(cam_enable),   32'h1);
      chk("t5_issue_data", 32'(cam_data_out), 32'(hold_data));
      @(negedge clk);
      @(negedge clk);
      chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'(g_oh));
      chk("t5_rsp_hit",   32'(bus.rsp_hit),   32'h1);
      chk("t5_rsp_addr",  32'(bus.rsp_addr),  32'(4 * g + 1));
      chk("t5_cnt",       32'(lookup_cnt),    32'(k + 1));
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Counter wrap: preload 0xFFFF, one more completion gives 0.
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    bus.req_valid = 4'b0010;
    bus.req_data[1*DATA_W +: DATA_W] = 16'h0040;
    #1;
    chk("t6_req_ready", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t6_rsp_addr",  32'(bus.rsp_addr),  32'h6);
    chk("t6_cnt_wrap",  32'(lookup_cnt),    32'h0);
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy),       32'h0);
    chk("t6_idle_cnt",  32'(lookup_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
